i_logic: RTL and testbench
==========================

// Module: i_logic
// PURPOSE
//  Control-unit decoder slice for LEGv8 logical instructions: ANDI/ORRI/EORI/ANDIS
//  (I-format) and AND/ORR/EOR/ANDS (R-format). Decodes a 32-bit instruction word
//  into a registered 94-bit control word (CW) for the datapath. Sits beside the
//  other per-class decoders; the top-level control unit muxes CWs by opcode class.
// PARAMETERS
//  none (all widths fixed by the LEGv8 ISA and the CW layout)
// PORTS
//  clock    in   1   single clock, rising-edge
//  reset    in   1   asynchronous, active-low reset
//  i        in   32  instruction word
//  CW       out  94  registered control word (layout below)
//  valid    out  1   registered: 1 = i was one of the 8 supported opcodes
// BEHAVIOUR
//  CW layout: [93] state | [92:29] k | [28] status_load | [27] B_sel | [26] PC_sel
//   | [25] memWrite | [24] regWrite | [23:22] enable | [21:20] PS | [19:15] FS
//   | [14:10] SB | [9:5] SA | [4:0] DA.
//  Decode (combinational, then registered; latency = 1 clock):
//   - I-format: i[31:22] = 1001001000 ANDI, 1011001000 ORRI, 1101001000 EORI,
//     1111001000 ANDIS. imm12 = i[21:10], Rn = i[9:5], Rd = i[4:0].
//   - R-format: i[31:21] = 10001010000 AND, 10101010000 ORR, 11001010000 EOR,
//     11101010000 ANDS. Rm = i[20:16], shamt i[15:10] ignored, Rn, Rd as above.
//   - Op from i[30:29]: 00 AND, 01 ORR, 10 EOR, 11 ANDS(flag-setting AND).
//  Field values for a supported opcode:
//   - DA = Rd; SA = Rn; SB = Rm (R-format), 5'd0 (I-format).
//   - FS: AND/ANDS/ANDI/ANDIS = 5'b00000, ORR/ORRI = 5'b00100, EOR/EORI = 5'b01100.
//   - k = {52'b0, imm12} (I-format), 64'd0 (R-format).
//   - B_sel = 1 (I-format, ALU B from k), 0 (R-format, ALU B from SB).
//   - status_load = 1 only for ANDS/ANDIS.
//   - regWrite = 1; memWrite = 0; PC_sel = 0; PS = 2'b01 (PC+4);
//     enable = 2'b00 (ALU drives data bus); state = 0; valid = 1.
//  Unsupported opcode: CW = NOP = all zero except PS = 2'b01; valid = 0.
//  Reset (reset = 0): CW and valid clear to 0 immediately, independent of clock,
//   and hold while reset low; first edge after release captures decode of i.
//  i changing every cycle: each edge captures that cycle's i; no internal state
//   beyond the output register.
// CONFIGURATION
//  I_LOGIC_SEXT_IMM_EN: when defined, I-format k = sign-extension of imm12
//   ({{52{imm12[11]}}, imm12}). When undefined (default), k is zero-extended.
//   R-format k = 0 in both builds.
// TESTING
//  1. Reset low with i = ANDI -> CW = 0, valid = 0 without any clock edge.
//  2. i = 1001001000_000000000001_00000_00001 (ANDI), one edge -> DA=1, SA=0, SB=0,
//     k=1, FS=00000, B_sel=1, status_load=0, regWrite=1, PS=01, valid=1.
//  3. i = 1111001000_000000001000_00110_00111 (ANDIS) -> DA=7, SA=6, k=8,
//     FS=00000, status_load=1; ORRI/EORI with imm 2/4 -> FS=00100/01100, k=2/4.
//  4. i = 10001010000_11111_000000_10000_00100 (AND) -> DA=4, SA=16, SB=31,
//     B_sel=0, k=0, status_load=0; EOR with Rm=7 -> SB=7, FS=01100.
//  5. i = 11101010000_00011_000000_10000_00100 (ANDS) -> SB=3, status_load=1.
//  6. i = 32'h0 -> valid=0, regWrite=0, PS=01; with I_LOGIC_SEXT_IMM_EN, ANDI
//     imm12 = 12'hFFF -> k = 64'hFFFF_FFFF_FFFF_FFFF (else 64'h0000_0000_0000_0FFF).

Source files
------------

// File: rtl/i_logic.sv
// LEGv8 logical-instruction decoder (ANDI/ORRI/EORI/ANDIS, AND/ORR/EOR/ANDS) producing a registered control word.
// Optional build macro: I_LOGIC_SEXT_IMM_EN sign-extends the I-format immediate into k.
module i_logic (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i,
  output logic [93:0] CW,
  output logic        valid
);

  localparam logic [1:0] PS_PC_PLUS4 = 2'b01;
  localparam logic [4:0] FS_AND      = 5'b00000;
  localparam logic [4:0] FS_ORR      = 5'b00100;
  localparam logic [4:0] FS_EOR      = 5'b01100;

  logic        is_imm;
  logic        is_reg;
  logic [1:0]  op;
  logic [11:0] imm12;
  logic [63:0] imm_ext;
  logic [4:0]  fs;
  logic [93:0] cw_next;
  logic        valid_next;

  // Both formats share i[31]=1 and carry the operation in i[30:29]; the rest is a fixed pattern.
  assign is_imm = i[31] && (i[28:22] == 7'b1001000);
  assign is_reg = i[31] && (i[28:21] == 8'b01010000);
  assign op     = i[30:29];
  assign imm12  = i[21:10];

`ifdef I_LOGIC_SEXT_IMM_EN
  assign imm_ext = {{52{imm12[11]}}, imm12};
`else
  assign imm_ext = {52'b0, imm12};
`endif

  always_comb begin
    fs = FS_AND;
    case (op)
      2'b01:   fs = FS_ORR;
      2'b10:   fs = FS_EOR;
      default: fs = FS_AND;
    endcase
  end

  always_comb begin
    cw_next        = '0;
    cw_next[21:20] = PS_PC_PLUS4;
    valid_next     = 1'b0;
    if (is_imm || is_reg) begin
      valid_next     = 1'b1;
      cw_next[93]    = 1'b0;
      cw_next[92:29] = is_imm ? imm_ext : 64'd0;
      cw_next[28]    = (op == 2'b11);
      cw_next[27]    = is_imm;
      cw_next[26]    = 1'b0;
      cw_next[25]    = 1'b0;
      cw_next[24]    = 1'b1;
      cw_next[23:22] = 2'b00;
      cw_next[19:15] = fs;
      cw_next[14:10] = is_imm ? 5'd0 : i[20:16];
      cw_next[9:5]   = i[9:5];
      cw_next[4:0]   = i[4:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      CW    <= '0;
      valid <= 1'b0;
    end else begin
      CW    <= cw_next;
      valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_i_logic.sv
// Self-checking bench for i_logic: directed cases plus random instructions against a table-driven model.
module tb_i_logic;

  logic        clock;
  logic        reset;
  logic [31:0] i;
  logic [93:0] CW;
  logic        valid;

  int checks   = 0;
  int failures = 0;

  i_logic dut (
    .clock(clock),
    .reset(reset),
    .i    (i),
    .CW   (CW),
    .valid(valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Mnemonic table: index = operation (0 AND, 1 ORR, 2 EOR, 3 ANDS).
  function automatic logic [9:0] imm_opcode(input int n);
    logic [9:0] t [4];
    t[0] = 10'b1001001000; t[1] = 10'b1011001000;
    t[2] = 10'b1101001000; t[3] = 10'b1111001000;
    return t[n];
  endfunction

  function automatic logic [10:0] reg_opcode(input int n);
    logic [10:0] t [4];
    t[0] = 11'b10001010000; t[1] = 11'b10101010000;
    t[2] = 11'b11001010000; t[3] = 11'b11101010000;
    return t[n];
  endfunction

  function automatic logic [4:0] alu_fs(input int n);
    logic [4:0] t [4];
    t[0] = 5'b00000; t[1] = 5'b00100; t[2] = 5'b01100; t[3] = 5'b00000;
    return t[n];
  endfunction

  function automatic logic [63:0] extend_imm(input logic [11:0] imm);
    logic [63:0] v;
    v = 64'(imm);
`ifdef I_LOGIC_SEXT_IMM_EN
    if (imm[11]) v = v - 64'd4096;
`endif
    return v;
  endfunction

  function automatic logic [93:0] nop_cw();
    logic [93:0] c;
    c = '0;
    c[21:20] = 2'b01;
    return c;
  endfunction

  function automatic logic [93:0] pack_cw(input logic [63:0] k, input logic sl, input logic bsel,
                                          input logic [4:0] fs, input logic [4:0] sb,
                                          input logic [4:0] sa, input logic [4:0] da);
    return {1'b0, k, sl, bsel, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, fs, sb, sa, da};
  endfunction

  // Reference: look the instruction up in the mnemonic tables and assemble the fields.
  function automatic void model(input logic [31:0] instr, output logic [93:0] cw, output logic v);
    cw = nop_cw();
    v  = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (instr[31:22] == imm_opcode(n)) begin
        cw = pack_cw(extend_imm(instr[21:10]), n == 3, 1'b1, alu_fs(n), 5'd0, instr[9:5], instr[4:0]);
        v  = 1'b1;
      end else if (instr[31:21] == reg_opcode(n)) begin
        cw = pack_cw(64'd0, n == 3, 1'b0, alu_fs(n), instr[20:16], instr[9:5], instr[4:0]);
        v  = 1'b1;
      end
    end
  endfunction

  task automatic check_vec(input string tag, input logic [93:0] observed, input logic [93:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] instr);
    @(negedge clock);
    i = instr;
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] instr);
    logic [93:0] exp_cw;
    logic        exp_v;
    model(instr, exp_cw, exp_v);
    check_vec({tag, ".cw"}, CW, exp_cw);
    check_vec({tag, ".valid"}, 94'(valid), 94'(exp_v));
  endtask

  logic [31:0] instr;
  logic [63:0] sext_k;

  initial begin
    $display("[TB] start");
    reset = 1'b1;
    i     = {10'b1001001000, 12'd5, 5'd2, 5'd3};
    repeat (2) @(posedge clock);
    #2;
    // Drop reset between edges: outputs must clear without a clock edge.
    reset = 1'b0;
    #1;
    check_vec("reset_async.cw", CW, 94'd0);
    check_vec("reset_async.valid", 94'(valid), 94'd0);
    @(posedge clock);
    #1;
    check_vec("reset_hold.cw", CW, 94'd0);
    check_vec("reset_hold.valid", 94'(valid), 94'd0);
    @(negedge clock);
    reset = 1'b1;

    instr = {10'b1001001000, 12'd1, 5'd0, 5'd1};
    apply_stimulus(instr);
    check_vec("andi.da", 94'(CW[4:0]), 94'd1);
    check_vec("andi.k", 94'(CW[92:29]), 94'd1);
    check_vec("andi.bsel_sl_rw", 94'({CW[27], CW[28], CW[24], CW[21:20]}), 94'(5'b10101));
    check_output("andi", instr);

    instr = {10'b1111001000, 12'd8, 5'd6, 5'd7};
    apply_stimulus(instr);
    check_vec("andis.fields", 94'({CW[4:0], CW[9:5], CW[19:15], CW[28]}), 94'({5'd7, 5'd6, 5'd0, 1'b1}));
    check_output("andis", instr);

    instr = {10'b1011001000, 12'd2, 5'd9, 5'd10};
    apply_stimulus(instr);
    check_vec("orri.fs_k", 94'({CW[19:15], CW[92:29]}), 94'({5'b00100, 64'd2}));

    instr = {10'b1101001000, 12'd4, 5'd11, 5'd12};
    apply_stimulus(instr);
    check_vec("eori.fs_k", 94'({CW[19:15], CW[92:29]}), 94'({5'b01100, 64'd4}));

    instr = {11'b10001010000, 5'd31, 6'd0, 5'd16, 5'd4};
    apply_stimulus(instr);
    check_vec("and.fields", 94'({CW[4:0], CW[9:5], CW[14:10], CW[27], CW[28]}), 94'({5'd4, 5'd16, 5'd31, 2'b00}));
    check_vec("and.k", 94'(CW[92:29]), 94'd0);

    instr = {11'b11001010000, 5'd7, 6'd0, 5'd16, 5'd4};
    apply_stimulus(instr);
    check_vec("eor.sb_fs", 94'({CW[14:10], CW[19:15]}), 94'({5'd7, 5'b01100}));

    instr = {11'b11101010000, 5'd3, 6'd0, 5'd16, 5'd4};
    apply_stimulus(instr);
    check_vec("ands.sb_sl", 94'({CW[14:10], CW[28]}), 94'({5'd3, 1'b1}));

    apply_stimulus(32'h0);
    check_vec("nop.cw", CW, {72'd0, 2'b01, 20'd0});
    check_vec("nop.valid", 94'(valid), 94'd0);

`ifdef I_LOGIC_SEXT_IMM_EN
    sext_k = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    sext_k = 64'h0000_0000_0000_0FFF;
`endif
    instr = {10'b1001001000, 12'hFFF, 5'd1, 5'd2};
    apply_stimulus(instr);
    check_vec("andi_fff.k", 94'(CW[92:29]), 94'(sext_k));

    // Random mix of supported encodings (random fields and shamt) and arbitrary words.
    for (int n = 0; n < 80; n++) begin
      int opi;
      opi = int'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: instr = {imm_opcode(opi), 22'($urandom)};
        1: instr = {reg_opcode(opi), 21'($urandom)};
        default: instr = $urandom;
      endcase
      apply_stimulus(instr);
      check_output($sformatf("rand%0d", n), instr);
    end

    // Reset mid-stream, then the first edge after release must decode the current word.
    #2;
    reset = 1'b0;
    #1;
    check_vec("reset_mid.cw", CW, 94'd0);
    @(negedge clock);
    reset = 1'b1;
    instr = {11'b10101010000, 5'd21, 6'd63, 5'd22, 5'd23};
    apply_stimulus(instr);
    check_output("after_reset_orr", instr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
